// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, RX FIFO entry layout and default sizing.
package uart_pkg;
  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_RX_TIMEOUT    = 60000;

  typedef struct packed {
    logic                   frame_err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Storage for the RX FIFO: DEPTH x rx_entry_t register array, synchronous write,
// asynchronous read so the head entry falls through to the CSR read path.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic          wb_clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rx_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output rx_entry_t     rdata
);
  rx_entry_t mem [DEPTH];

  always_ff @(posedge wb_clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO between UART receiver and CSR block, with level/overflow
// interrupt. Define UART_RX_TIMEOUT_EN to add the idle-timeout interrupt source.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = 4
`ifdef UART_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = UART_RX_TIMEOUT
`endif
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   rx_valid,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_frame_err,
  output logic                   rx_finish,
  input  logic                   rd_en,
  output logic [UART_DATA_W:0]   rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [AW:0]            level,
  input  logic [AW:0]            thresh,
  input  logic                   irq_en,
  input  logic                   clr,
  output logic                   overflow,
  output logic                   irq
);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg, level_next;
  logic          empty_reg, full_reg, overflow_reg, irq_reg, rx_finish_reg;
  logic          do_push, do_pop, tmo_flag;
  rx_entry_t     wr_entry, rd_entry;

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign do_pop  = rd_en && !empty_reg;
  assign do_push = rx_valid && (!full_reg || do_pop);

  always_comb begin
    level_next = level_reg;
    if (do_push && !do_pop)      level_next = level_reg + 1'b1;
    else if (do_pop && !do_push) level_next = level_reg - 1'b1;
  end

  assign wr_entry = '{frame_err: rx_frame_err, data: rx_data};

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .wb_clk_i (wb_clk_i),
    .we       (do_push && !clr),
    .waddr    (wr_ptr_reg),
    .wdata    (wr_entry),
    .raddr    (rd_ptr_reg),
    .rdata    (rd_entry)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      irq_reg       <= 1'b0;
      rx_finish_reg <= 1'b0;
    end else begin
      rx_finish_reg <= rx_valid;
      irq_reg <= irq_en && (((thresh != '0) && (level_reg >= thresh)) || overflow_reg || tmo_flag);
      if (clr) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        level_reg    <= '0;
        empty_reg    <= 1'b1;
        full_reg     <= 1'b0;
        overflow_reg <= 1'b0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        level_reg <= level_next;
        empty_reg <= (level_next == '0);
        full_reg  <= (level_next == FULL_LEVEL);
        if (rx_valid && !do_push) overflow_reg <= 1'b1;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [31:0] timer_reg;
  logic        tmo_flag_reg;

  // Idle timer restarts on any FIFO activity; the flag survives pushes until the next pop.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      timer_reg    <= '0;
      tmo_flag_reg <= 1'b0;
    end else if (clr) begin
      timer_reg    <= '0;
      tmo_flag_reg <= 1'b0;
    end else if (do_push || do_pop) begin
      timer_reg <= '0;
      if (do_pop) tmo_flag_reg <= 1'b0;
    end else if (!empty_reg) begin
      if (timer_reg == 32'(TIMEOUT_CYCLES - 1)) tmo_flag_reg <= 1'b1;
      else                                     timer_reg    <= timer_reg + 1'b1;
    end
  end

  assign tmo_flag = tmo_flag_reg;
`else
  assign tmo_flag = 1'b0;
`endif

  assign rd_data   = rd_entry;
  assign empty     = empty_reg;
  assign full      = full_reg;
  assign level     = level_reg;
  assign overflow  = overflow_reg;
  assign irq       = irq_reg;
  assign rx_finish = rx_finish_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
// Define UART_RX_TIMEOUT_EN to also exercise the idle-timeout source (TIMEOUT_CYCLES=100).
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_RX_TIMEOUT_EN
  localparam int TMO = 100;
`endif

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_frame_err = 1'b0;
  logic       rx_finish;
  logic       rd_en = 1'b0;
  logic [8:0] rd_data;
  logic       empty, full;
  logic [AW:0] level;
  logic [AW:0] thresh = '0;
  logic       irq_en = 1'b0;
  logic       clr = 1'b0;
  logic       overflow, irq;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [8:0] q[$];
  bit m_ovf = 0, m_tmo = 0;
  int m_idle = 0;
  bit exp_finish = 0, exp_irq = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  uart_rx_fifo #(
    .DEPTH(DEPTH), .AW(AW)
`ifdef UART_RX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_finish(rx_finish), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .level(level), .thresh(thresh), .irq_en(irq_en),
    .clr(clr), .overflow(overflow), .irq(irq)
  );

  // Drives one clock cycle and advances the model; outputs are settled on return.
  task automatic step(input bit v, input logic [7:0] d, input bit fe, input bit r, input bit c);
    bit pop, push;
    int n;
    rx_valid = v; rx_data = d; rx_frame_err = fe; rd_en = r; clr = c;
    n = q.size();
    exp_irq = irq_en && ((thresh != 0 && n >= int'(thresh)) || m_ovf || m_tmo);
    exp_finish = v;
    if (c) begin
      q.delete(); m_ovf = 0; m_tmo = 0; m_idle = 0;
    end else begin
      pop  = r && n > 0;
      push = v && (n < DEPTH || pop);
      if (v && !push) m_ovf = 1;
      if (push || pop) begin
        m_idle = 0;
        if (pop) m_tmo = 0;
      end
`ifdef UART_RX_TIMEOUT_EN
      else if (n > 0) begin
        if (m_idle == TMO - 1) m_tmo = 1;
        else m_idle++;
      end
`endif
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({fe, d});
    end
    @(posedge wb_clk_i); #1;
    rx_valid = 0; rd_en = 0; clr = 0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    tests_run++;
    if ({level, empty, full, rx_finish, overflow, irq} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got level=%0d empty=%b full=%b fin=%b ovf=%b irq=%b expected 0/1/0/0/0/0",
               level, empty, full, rx_finish, overflow, irq);
    end
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    $display("[TB] reset: level=%0d empty=%b", level, empty);
  endtask

  task automatic test_basic();
    logic [7:0] bytes [3];
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    irq_en = 0; thresh = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, bytes[i], 0, 0, 0);
      tests_run++;
      if (rx_finish !== 1'b1) begin
        tests_failed++; $display("FAIL basic_ack%0d: got %b expected 1", i, rx_finish);
      end
      step(0, 8'h00, 0, 0, 0);
      tests_run++;
      if (rx_finish !== 1'b0) begin
        tests_failed++; $display("FAIL basic_ack_pulse%0d: got %b expected 0", i, rx_finish);
      end
      $display("[TB] basic push 0x%02h level=%0d", bytes[i], level);
    end
    tests_run++;
    if (level !== 5'd3 || rd_data !== 9'h041) begin
      tests_failed++; $display("FAIL basic_level_head: got level=%0d rd=%h expected 3/041", level, rd_data);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rd_data !== {1'b0, bytes[i]}) begin
        tests_failed++; $display("FAIL basic_pop%0d: got %h expected %h", i, rd_data, {1'b0, bytes[i]});
      end
      $display("[TB] basic pop %h", rd_data);
      step(0, 8'h00, 0, 1, 0);
    end
    tests_run++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      tests_failed++; $display("FAIL basic_empty: got empty=%b level=%0d expected 1/0", empty, level);
    end
  endtask

  task automatic test_overflow();
    irq_en = 1; thresh = 0;
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 1'($urandom), 0, 0);
    tests_run++;
    if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_fill: got full=%b level=%0d ovf=%b expected 1/16/0", full, level, overflow);
    end
    step(1, 8'hEE, 0, 0, 0);
    tests_run++;
    if (rx_finish !== 1'b1 || overflow !== 1'b1 || level !== 5'd16 || irq !== exp_irq) begin
      tests_failed++;
      $display("FAIL ovf_drop: got fin=%b ovf=%b level=%0d irq=%b expected 1/1/16/%b", rx_finish, overflow, level, irq, exp_irq);
    end
    step(0, 8'h00, 0, 0, 0);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_irq: got %b expected 1", irq);
    end
    $display("[TB] overflow: ovf=%b irq=%b", overflow, irq);
    step(0, 8'h00, 0, 0, 1);
    tests_run++;
    if (level !== 5'd0 || overflow !== 1'b0 || empty !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_clr: got level=%0d ovf=%b empty=%b expected 0/0/1", level, overflow, empty);
    end
    step(0, 8'h00, 0, 0, 0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_clr_irq: got %b expected 0", irq);
    end
    irq_en = 0;
  endtask

  task automatic test_full_push_pop();
    logic [8:0] oldest;
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 1'($urandom), 0, 0);
    oldest = q[0];
    tests_run++;
    if (rd_data !== oldest) begin
      tests_failed++; $display("FAIL fpp_head: got %h expected %h", rd_data, oldest);
    end
    step(1, 8'hA5, 1, 1, 0);
    tests_run++;
    if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL fpp_level: got level=%0d full=%b ovf=%b expected 16/1/0", level, full, overflow);
    end
    $display("[TB] full push+pop: popped %h level=%0d", oldest, level);
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (rd_data !== q[0]) begin
        tests_failed++; $display("FAIL fpp_drain%0d: got %h expected %h", i, rd_data, q[0]);
      end
      if (i == 15) begin
        tests_run++;
        if (rd_data !== 9'h1A5) begin
          tests_failed++; $display("FAIL fpp_last: got %h expected 1a5", rd_data);
        end
      end
      step(0, 8'h00, 0, 1, 0);
    end
  endtask

  task automatic test_threshold();
    step(0, 8'h00, 0, 0, 1);
    thresh = 5'd4; irq_en = 1;
    for (int i = 0; i < 3; i++) step(1, 8'(i + 1), 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL thr_below: got %b expected 0", irq);
    end
    step(1, 8'h04, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    tests_run++;
    if (irq !== 1'b1 || level !== 5'd4) begin
      tests_failed++; $display("FAIL thr_reach: got irq=%b level=%0d expected 1/4", irq, level);
    end
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL thr_pop: got %b expected 0", irq);
    end
    $display("[TB] threshold: level=%0d irq=%b", level, irq);
    step(0, 8'h00, 0, 0, 1);
    thresh = 0; irq_en = 0;
  endtask

  task automatic test_frame_err_wrap();
    logic [7:0] b;
    step(1, 8'h55, 1, 0, 0);
    tests_run++;
    if (rd_data !== 9'h155) begin
      tests_failed++; $display("FAIL ferr_data: got %h expected 155", rd_data);
    end
    step(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      step(1, b, 1'(i), 0, 0);
      tests_run++;
      if (rd_data !== {1'(i), b} || level > 5'd1) begin
        tests_failed++; $display("FAIL wrap%0d: got %h level=%0d expected %h level<=1", i, rd_data, level, {1'(i), b});
      end
      step(0, 8'h00, 0, 1, 0);
    end
    $display("[TB] wrap: 40 pairs, level=%0d empty=%b", level, empty);
  endtask

  task automatic test_random();
    bit v, r, c;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) thresh = 5'($urandom_range(0, 16));
      if ($urandom_range(0, 15) == 0) irq_en = 1'($urandom);
      v = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 4);
      c = ($urandom_range(0, 63) == 0);
      step(v, 8'($urandom), 1'($urandom), r, c);
      tests_run++;
      if (level !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          overflow !== m_ovf || irq !== exp_irq || rx_finish !== exp_finish ||
          (q.size() > 0 && rd_data !== q[0])) begin
        tests_failed++;
        $display("FAIL random%0d: got level=%0d ovf=%b irq=%b fin=%b rd=%h expected level=%0d ovf=%b irq=%b fin=%b rd=%h",
                 i, level, overflow, irq, rx_finish, rd_data, q.size(), m_ovf, exp_irq, exp_finish,
                 (q.size() > 0) ? q[0] : 9'h0);
      end
    end
    $display("[TB] random: 400 cycles, final level=%0d", level);
    step(0, 8'h00, 0, 0, 1);
    thresh = 0; irq_en = 0;
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic test_timeout();
    int rise;
    irq_en = 1; thresh = 0;
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h77, 0, 0, 0);
    rise = -1;
    for (int i = 1; i <= 200 && rise < 0; i++) begin
      step(0, 8'h00, 0, 0, 0);
      tests_run++;
      if (irq !== exp_irq) begin
        tests_failed++; $display("FAIL tmo_model%0d: got %b expected %b", i, irq, exp_irq);
      end
      if (irq === 1'b1) rise = i;
    end
    tests_run++;
    if (rise < 95 || rise > 105) begin
      tests_failed++; $display("FAIL tmo_rise: got cycle %0d expected about 101", rise);
    end
    $display("[TB] timeout: irq rose after %0d idle cycles", rise);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL tmo_pop: got %b expected 0", irq);
    end
    step(1, 8'h01, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step((i % 50) == 49, 8'(i), 0, 0, 0);
      tests_run++;
      if (irq !== 1'b0) begin
        tests_failed++; $display("FAIL tmo_keepalive%0d: got %b expected 0", i, irq);
      end
    end
    $display("[TB] timeout keepalive: level=%0d irq=%b", level, irq);
    step(0, 8'h00, 0, 0, 1);
    irq_en = 0;
  endtask
`endif

  task automatic test_async_reset();
    irq_en = 1;
    for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0, 0);
    rx_valid = 1; rx_data = 8'h99;
    @(posedge wb_clk_i); #1;
    rx_valid = 0;
    tests_run++;
    if (rx_finish !== 1'b1) begin
      tests_failed++; $display("FAIL arst_pre_ack: got %b expected 1", rx_finish);
    end
    #2 wb_rst_i = 1'b1;
    #1;
    tests_run++;
    if ({rx_finish, level, empty, full, overflow, irq} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL arst_state: got fin=%b level=%0d empty=%b full=%b ovf=%b irq=%b expected 0/0/1/0/0/0",
               rx_finish, level, empty, full, overflow, irq);
    end
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    q.delete(); m_ovf = 0; m_tmo = 0; m_idle = 0;
    irq_en = 0;
    step(1, 8'h3C, 0, 0, 0);
    tests_run++;
    if (level !== 5'd1 || rd_data !== 9'h03C) begin
      tests_failed++; $display("FAIL arst_after: got level=%0d rd=%h expected 1/03c", level, rd_data);
    end
    $display("[TB] async reset: level=%0d after one push", level);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_threshold();
    test_frame_err_wrap();
    test_random();
`ifdef UART_RX_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
